// File: rtl/axi_tdd_frame_counter.sv
// TDD frame counter: arms on enable, starts on sync (+startup delay), counts frames per burst.
// Latency: state/counters registered, end-of-frame/burst combinational; no backpressure.
module axi_tdd_frame_counter #(
   parameter int REG_WIDTH   = 32,
   parameter int BURST_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   tdd_enable,
   input  logic                   tdd_sync,
   input  logic                   tdd_sync_rst,
   input  logic [REG_WIDTH-1:0]   asy_tdd_startup_delay,
   input  logic [REG_WIDTH-1:0]   asy_tdd_frame_length,
   input  logic [BURST_WIDTH-1:0] asy_tdd_burst_count,
   output logic [REG_WIDTH-1:0]   tdd_counter,
   output logic [BURST_WIDTH-1:0] tdd_frame_index,
   output logic [1:0]             tdd_cstate,
   output logic                   tdd_endof_frame,
   output logic                   tdd_endof_burst,
   output logic                   tdd_armed
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_WAITING = 2'd2,
      ST_RUNNING = 2'd3
   } state_t;

   localparam logic [REG_WIDTH-1:0]   REG_ONE   = REG_WIDTH'(1);
   localparam logic [BURST_WIDTH-1:0] BURST_ONE = BURST_WIDTH'(1);

   state_t                 state_q, state_d;
   logic [REG_WIDTH-1:0]   cnt_q, cnt_d;
   logic [BURST_WIDTH-1:0] idx_q, idx_d;
   logic [REG_WIDTH-1:0]   delay_q, len_q;
   logic [BURST_WIDTH-1:0] burst_q;
   logic                   en_q;
   logic                   armed_q;
   logic                   sync_restart;
   logic                   frame_end;
   logic                   burst_end;

   // A restart sync pre-empts the end-of-frame/burst indications of the same cycle.
   assign sync_restart = (state_q == ST_RUNNING) && tdd_sync && tdd_sync_rst;
   assign frame_end    = (state_q == ST_RUNNING) && (cnt_q == len_q - REG_ONE) && !sync_restart;
   assign burst_end    = frame_end && (burst_q != '0) && (idx_q == burst_q - BURST_ONE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      if (!tdd_enable) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               idx_d = '0;
               if (!en_q) state_d = ST_ARMED;
            end
            ST_ARMED: begin
               if (tdd_sync) begin
                  state_d = (delay_q != '0) ? ST_WAITING : ST_RUNNING;
                  cnt_d   = '0;
               end
            end
            ST_WAITING: begin
               if (cnt_q == delay_q - REG_ONE) begin
                  state_d = ST_RUNNING;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + REG_ONE;
               end
            end
            ST_RUNNING: begin
               if (sync_restart) begin
                  state_d = (delay_q != '0) ? ST_WAITING : ST_RUNNING;
                  cnt_d   = '0;
                  idx_d   = '0;
               end else if (frame_end) begin
                  cnt_d = '0;
                  if (burst_end) begin
                     state_d = ST_IDLE;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + BURST_ONE;
                  end
               end else begin
                  cnt_d = cnt_q + REG_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end
         endcase
      end
   end

   // en_q resets high so an enable held through reset needs a fresh rising edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         en_q    <= 1'b1;
         armed_q <= 1'b0;
         delay_q <= '0;
         len_q   <= '0;
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         en_q    <= tdd_enable;
         armed_q <= (state_d == ST_ARMED);
         if (state_q == ST_IDLE) begin
            delay_q <= asy_tdd_startup_delay;
            len_q   <= asy_tdd_frame_length;
            burst_q <= asy_tdd_burst_count;
         end
      end
   end

   assign tdd_counter     = cnt_q;
   assign tdd_frame_index = idx_q;
   assign tdd_cstate      = state_q;
   assign tdd_endof_frame = frame_end;
   assign tdd_endof_burst = burst_end;
   assign tdd_armed       = armed_q;

endmodule

// File: tb/tb_axi_tdd_frame_counter.sv
// Bench for axi_tdd_frame_counter: timeline reference model plus directed and random scenarios.
module tb_axi_tdd_frame_counter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        en, sync, srst;
   logic [31:0] dly, len, bur;
   logic [31:0] tdd_counter, tdd_frame_index;
   logic [1:0]  tdd_cstate;
   logic        tdd_endof_frame, tdd_endof_burst, tdd_armed;
   logic [68:0] dut_vec;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   axi_tdd_frame_counter #(.REG_WIDTH(32), .BURST_WIDTH(32)) dut (
      .clk                   (clk),
      .resetn                (resetn),
      .tdd_enable            (en),
      .tdd_sync              (sync),
      .tdd_sync_rst          (srst),
      .asy_tdd_startup_delay (dly),
      .asy_tdd_frame_length  (len),
      .asy_tdd_burst_count   (bur),
      .tdd_counter           (tdd_counter),
      .tdd_frame_index       (tdd_frame_index),
      .tdd_cstate            (tdd_cstate),
      .tdd_endof_frame       (tdd_endof_frame),
      .tdd_endof_burst       (tdd_endof_burst),
      .tdd_armed             (tdd_armed)
   );

   assign dut_vec = {tdd_cstate, tdd_armed, tdd_endof_frame, tdd_endof_burst, tdd_counter, tdd_frame_index};

   // Reference model: mode 0 idle, 1 armed, 2 active; when active, m_t counts edges since the
   // accepted sync and the expected position follows from delay/length/burst by division.
   int          m_mode;
   longint      m_t;
   logic        m_prev_en;
   logic [31:0] sh_del, sh_len, sh_bur;

   function automatic void derive(input longint e, output logic [1:0] st,
                                  output logic [31:0] cnt, output logic [31:0] idx);
      longint lenv, r, fr;
      lenv = (sh_len == 0) ? 64'd4294967296 : {32'd0, sh_len};
      st = 2'd0; cnt = 32'd0; idx = 32'd0;
      if (sh_del != 0 && e < {32'd0, sh_del}) begin
         st  = 2'd2;
         cnt = 32'(e);
      end else begin
         r  = e - {32'd0, sh_del};
         fr = r / lenv;
         if (!(sh_bur != 0 && fr >= {32'd0, sh_bur})) begin
            st  = 2'd3;
            cnt = 32'(r % lenv);
            idx = 32'(fr);
         end
      end
   endfunction

   function automatic void model_cur(output logic [1:0] st, output logic [31:0] cnt,
                                     output logic [31:0] idx);
      st = 2'd0; cnt = 32'd0; idx = 32'd0;
      if (m_mode == 1) st = 2'd1;
      else if (m_mode == 2) derive(m_t, st, cnt, idx);
   endfunction

   function automatic logic [68:0] model_vec();
      logic [1:0]  st;
      logic [31:0] cnt, idx;
      logic        eof, eob;
      model_cur(st, cnt, idx);
      eof = (st == 2'd3) && (cnt == sh_len - 32'd1) && !(sync && srst);
      eob = eof && (sh_bur != 0) && (idx == sh_bur - 32'd1);
      return {st, (st == 2'd1), eof, eob, cnt, idx};
   endfunction

   function automatic void model_reset();
      m_mode = 0; m_t = 0; m_prev_en = 1'b1;
      sh_del = 32'd0; sh_len = 32'd0; sh_bur = 32'd0;
   endfunction

   function automatic void model_step();
      logic [1:0]  st;
      logic [31:0] cnt, idx;
      if (m_mode == 0) begin
         sh_del = dly; sh_len = len; sh_bur = bur;
      end
      if (!en) m_mode = 0;
      else if (m_mode == 0) begin
         if (!m_prev_en) m_mode = 1;
      end else if (m_mode == 1) begin
         if (sync) begin m_mode = 2; m_t = 0; end
      end else begin
         derive(m_t, st, cnt, idx);
         if (st == 2'd3 && sync && srst) m_t = 0;
         else begin
            m_t = m_t + 1;
            derive(m_t, st, cnt, idx);
            if (st == 2'd0) m_mode = 0;
         end
      end
      m_prev_en = en;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; en = 0; sync = 0; srst = 0;
      dly = 32'd3; len = 32'd7; bur = 32'd2;
      model_reset();
      #3;
      total++;
      if (dut_vec !== 69'd0) begin
         bad++; $display("FAIL reset_state got=%h exp=%h", dut_vec, 69'd0);
      end
      @(posedge clk); @(posedge clk); #1;
      resetn = 1'b1;
   endtask

   task automatic test_basic_burst();
      dly = 0; len = 10; bur = 2; srst = 0;
      for (int c = 0; c < 30; c++) begin
         en = (c >= 1); sync = (c == 3);
         #2; total++;
         if (dut_vec !== model_vec()) begin
            bad++; $display("FAIL basic c=%0d got=%h exp=%h", c, dut_vec, model_vec());
         end
         if (c == 4) begin
            total++;
            if (tdd_cstate !== 2'd3 || tdd_counter !== 32'd0) begin
               bad++; $display("FAIL basic_start st=%0d cnt=%0d exp st=3 cnt=0", tdd_cstate, tdd_counter);
            end
         end
         tick();
      end
   endtask

   task automatic test_startup_delay();
      dly = 5; len = 4; bur = 2; srst = 1;
      for (int c = 0; c < 26; c++) begin
         en = (c >= 1); sync = (c == 3 || c == 6);
         #2; total++;
         if (dut_vec !== model_vec()) begin
            bad++; $display("FAIL delay c=%0d got=%h exp=%h", c, dut_vec, model_vec());
         end
         if (c == 8 || c == 9) begin
            total++;
            if (tdd_cstate !== ((c == 8) ? 2'd2 : 2'd3) || tdd_counter !== ((c == 8) ? 32'd4 : 32'd0)) begin
               bad++; $display("FAIL delay_edge c=%0d st=%0d cnt=%0d", c, tdd_cstate, tdd_counter);
            end
         end
         tick();
      end
   endtask

   task automatic test_infinite_restart();
      logic [1:0]  st;
      logic [31:0] cnt, idx;
      int          phase = 0;
      dly = 0; len = 8; bur = 0; srst = 1;
      for (int c = 0; c < 70; c++) begin
         model_cur(st, cnt, idx);
         en = (c >= 1);
         sync = (c == 3);
         if (c > 3 && st == 2'd3) begin
            if (phase == 0 && idx >= 1 && cnt == 6) begin sync = 1; phase = 1; end
            else if (phase == 1 && idx >= 1 && cnt == 7) begin sync = 1; phase = 2; end
            else if (phase == 2 && idx >= 1 && cnt == 6) begin srst = 0; sync = 1; phase = 3; end
         end
         #2; total++;
         if (dut_vec !== model_vec()) begin
            bad++; $display("FAIL restart c=%0d got=%h exp=%h", c, dut_vec, model_vec());
         end
         tick();
      end
      total++;
      if (phase != 3) begin
         bad++; $display("FAIL restart_phases got=%0d exp=3", phase);
      end
   endtask

   task automatic test_disable();
      dly = 0; len = 8; bur = 0; srst = 0;
      for (int c = 0; c < 30; c++) begin
         en = (c >= 1 && c != 7 && c != 8); sync = (c == 3 || c == 11);
         if (c == 8) len = 5;
         if (c == 14) len = 9;
         #2; total++;
         if (dut_vec !== model_vec()) begin
            bad++; $display("FAIL disable c=%0d got=%h exp=%h", c, dut_vec, model_vec());
         end
         if (c == 8) begin
            total++;
            if (tdd_cstate !== 2'd0 || tdd_counter !== 32'd0) begin
               bad++; $display("FAIL disable_idle st=%0d cnt=%0d exp st=0 cnt=0", tdd_cstate, tdd_counter);
            end
         end
         if (c == 16) begin
            total++;
            if (tdd_endof_frame !== 1'b1 || tdd_counter !== 32'd4) begin
               bad++; $display("FAIL disable_newlen eof=%0b cnt=%0d exp eof=1 cnt=4", tdd_endof_frame, tdd_counter);
            end
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      dly = 0; len = 6; bur = 0; srst = 0;
      for (int c = 0; c < 10; c++) begin
         en = (c >= 1); sync = (c == 3);
         #2; total++;
         if (dut_vec !== model_vec()) begin
            bad++; $display("FAIL areset_pre c=%0d got=%h exp=%h", c, dut_vec, model_vec());
         end
         tick();
      end
      #2; resetn = 1'b0;
      #1; total++;
      if (dut_vec !== 69'd0) begin
         bad++; $display("FAIL areset_immediate got=%h exp=%h", dut_vec, 69'd0);
      end
      model_reset();
      @(posedge clk); #1;
      resetn = 1'b1;
      for (int c = 0; c < 12; c++) begin
         en = (c != 6); sync = (c == 2 || c == 9);
         #2; total++;
         if (dut_vec !== model_vec()) begin
            bad++; $display("FAIL areset_post c=%0d got=%h exp=%h", c, dut_vec, model_vec());
         end
         if (c == 5) begin
            total++;
            if (tdd_cstate !== 2'd0) begin
               bad++; $display("FAIL areset_noarm st=%0d exp=0", tdd_cstate);
            end
         end
         tick();
      end
   endtask

   task automatic test_edge_cases();
      dly = 0; len = 3; bur = 1; srst = 0;
      for (int c = 0; c < 19; c++) begin
         en = (c >= 1 && c != 10);
         sync = (c <= 1 || c == 4 || c == 13);
         if (c == 9) len = 1;
         #2; total++;
         if (dut_vec !== model_vec()) begin
            bad++; $display("FAIL edge c=%0d got=%h exp=%h", c, dut_vec, model_vec());
         end
         if (c == 3) begin
            total++;
            if (tdd_cstate !== 2'd1 || tdd_armed !== 1'b1) begin
               bad++; $display("FAIL edge_armed st=%0d armed=%0b exp st=1 armed=1", tdd_cstate, tdd_armed);
            end
         end
         if (c == 14) begin
            total++;
            if ({tdd_cstate, tdd_endof_frame, tdd_endof_burst} !== 4'b1111) begin
               bad++; $display("FAIL edge_single st=%0d eof=%0b eob=%0b exp st=3 eof=1 eob=1",
                               tdd_cstate, tdd_endof_frame, tdd_endof_burst);
            end
         end
         tick();
      end
   endtask

   task automatic test_random();
      int en_off = 2;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 39) == 0) begin
            dly = $urandom_range(0, 6);
            len = $urandom_range(1, 12);
            bur = $urandom_range(0, 4);
         end
         if ($urandom_range(0, 19) == 0) srst = ~srst;
         if (en_off == 0 && ($urandom_range(0, 119) == 0 ||
                             (m_mode == 0 && $urandom_range(0, 7) == 0)))
            en_off = $urandom_range(1, 3);
         en = (en_off == 0);
         if (en_off > 0) en_off--;
         sync = ($urandom_range(0, 13) == 0);
         #2; total++;
         if (dut_vec !== model_vec()) begin
            bad++; $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec, model_vec());
         end
         tick();
      end
   endtask

   initial begin
      srst = 1'b0;
      test_reset();
      test_basic_burst();
      test_startup_delay();
      test_infinite_restart();
      test_disable();
      test_async_reset();
      test_edge_cases();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
